// File: rtl/lif_cfg_pkg.sv
// rtl/lif_cfg_pkg.sv - shared types and constants for the LIF parameter loader
package lif_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_READY,
        DONE
    } loader_state_t;

    localparam int PARAM_BITS  = 32;
    localparam int PARAM_BYTES = 4;

    // Serial configuration port expects byte 3 bit 7 first.
    localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/lif_cfg_shifter.sv
// rtl/lif_cfg_shifter.sv - parallel-load shift register with bit counter and last flag
module lif_cfg_shifter
    import lif_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  load,
    input  logic                  shift,
    input  logic [PARAM_BITS-1:0] din,
    output logic                  bit_out,
    output logic                  last
);

    logic [PARAM_BITS-1:0] data;
    logic [5:0]            cnt;

    // Zeros are shifted in, so the output bit is 0 once the image has gone out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
            cnt  <= '0;
        end else if (ena) begin
            if (load) begin
                data <= din;
                cnt  <= '0;
            end else if (shift) begin
                data <= MSB_FIRST ? {data[PARAM_BITS-2:0], 1'b0}
                                  : {1'b0, data[PARAM_BITS-1:1]};
                cnt  <= cnt + 6'd1;
            end
        end
    end

    assign bit_out = MSB_FIRST ? data[PARAM_BITS-1] : data[0];
    assign last    = (cnt == 6'(PARAM_BITS - 1));

endmodule

// File: rtl/lif_param_loader.sv
// rtl/lif_param_loader.sv - parameter image store and serial load sequencer for the LIF neuron
module lif_param_loader
    import lif_cfg_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic       run_req,
    input  logic       params_ready,
    output logic       load_mode,
    output logic       serial_data,
    output logic       input_enable,
    output logic       busy,
    output logic       done,
    output logic       error
);

    loader_state_t state, state_next;

    logic [PARAM_BYTES-1:0][7:0] image;
    logic [7:0]                  wcnt;
    logic                        shift_last;
    logic                        in_idle;
    logic                        in_wait;
    logic                        wait_expired;
    logic                        load_req;

    assign in_idle      = (state == IDLE);
    assign in_wait      = (state == WAIT_READY);
    assign wait_expired = (wcnt == 8'(WAIT_MAX - 1));
    assign load_req     = in_idle && start;

    // Snapshot samples the image before this cycle's write lands.
    lif_cfg_shifter u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .load    (load_req),
        .shift   (state == SHIFT),
        .din     (image),
        .bit_out (serial_data),
        .last    (shift_last)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start) state_next = SHIFT;
            SHIFT:      if (shift_last) state_next = WAIT_READY;
            WAIT_READY: begin
                if (params_ready)      state_next = DONE;
                else if (wait_expired) state_next = IDLE;
            end
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            image     <= '0;
            wcnt      <= '0;
            load_mode <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else if (ena) begin
            state     <= state_next;
            load_mode <= (state_next == SHIFT);
            busy      <= (state_next == SHIFT) || (state_next == WAIT_READY);
            done      <= (state_next == DONE);

            if (in_idle && wr_en) begin
                image[wr_addr] <= wr_data;
            end

            if (state == SHIFT) begin
                wcnt <= '0;
            end else if (in_wait && !params_ready && !wait_expired) begin
                wcnt <= wcnt + 8'd1;
            end

            if (load_req) begin
                error <= 1'b0;
            end else if (in_wait && !params_ready && wait_expired) begin
                error <= 1'b1;
            end
        end
    end

    assign input_enable = run_req & ~busy;

endmodule
